// File: rtl/serial_addsub_seq.sv
// Bit-serial two's-complement add/subtract sequencer: one full-adder cell, LSB first, one bit per clock.
// Optional macro SERIAL_ADDSUB_SAT_EN: saturate s on signed overflow (cout/overflow still report the wrapped result).
module serial_addsub_seq #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         overflow
);

    localparam int cw = $clog2(n);
    localparam logic [cw-1:0] last = cw'(n - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [cw-1:0] cnt;
    logic [n-1:0]  a_sh, b_sh, res_sh;
    logic          carry, xs, bs;

    logic          sum_bit, carry_nx, ovf_nx;
    logic [n-1:0]  res_nx, s_fin;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The last CALC edge commits the result, so flags are derived from the shifted-in final bit.
    always_comb begin
        sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_nx   = {sum_bit, res_sh[n-1:1]};
        ovf_nx   = (xs & bs & ~res_nx[n-1]) | (~xs & ~bs & res_nx[n-1]);
        s_fin    = res_nx;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_nx) s_fin = xs ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            xs       <= 1'b0;
            bs       <= 1'b0;
            s        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= x;
                        b_sh   <= op ? ~y : y;
                        carry  <= op;
                        cnt    <= '0;
                        res_sh <= '0;
                        xs     <= x[n-1];
                        bs     <= op ? ~y[n-1] : y[n-1];
                    end
                end
                CALC: begin
                    a_sh   <= {1'b0, a_sh[n-1:1]};
                    b_sh   <= {1'b0, b_sh[n-1:1]};
                    carry  <= carry_nx;
                    res_sh <= res_nx;
                    cnt    <= cnt + cw'(1);
                    if (cnt == last) begin
                        s        <= s_fin;
                        cout     <= carry_nx;
                        overflow <= ovf_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq (n=4): vector table plus hand-written multi-cycle sequences.
module tb_serial_addsub_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n, start, op;
    logic [N-1:0] x, y;
    logic         busy, done, cout, overflow;
    logic [N-1:0] s;

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] prev_s;

    typedef struct {
        logic         op;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[11];

    serial_addsub_seq #(.n(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and return the number of edges after acceptance until done is seen.
    task automatic applyStimulus(input logic op_i, input logic [N-1:0] x_i, input logic [N-1:0] y_i,
                                 output int lat);
        @(negedge clk);
        start = 1'b1; op = op_i; x = x_i; y = y_i;
        @(posedge clk); #1;
        start = 1'b0; x = '0; y = '0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("s_stable_during_op", 32'(s), 32'(prev_s));
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, pulses;
        int t[3];
        logic [N-1:0] s_at_done;

        vecs[0]  = '{1'b1, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'h3, 4'h8, 4'hB, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'h6, 4'h5, 4'hB, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 4'hF, 4'hE, 4'hD, 1'b1, 1'b0};
`ifdef SERIAL_ADDSUB_SAT_EN
        vecs[1].s = 4'h7;
        vecs[2].s = 4'h8;
        vecs[5].s = 4'h8;
        vecs[7].s = 4'h7;
        vecs[9].s = 4'h7;
`endif

        rst_n = 1'b0; start = 1'b0; op = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_s", 32'(s), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        prev_s = '0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, lat);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(N));
            checkOutput($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].s));
            checkOutput($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            checkOutput($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            prev_s = vecs[i].s;
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            checkOutput($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
        end

        // busy must span exactly n+1 cycles for 5-3
        @(negedge clk);
        start = 1'b1; op = 1'b1; x = 4'h5; y = 4'h3;
        bcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) bcnt++;
        end
        checkOutput("busy_cycles", 32'(bcnt), 32'd5);
        checkOutput("busy_s", 32'(s), 32'h2);
        prev_s = 4'h2;

        // second start while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; x = 4'h3; y = 4'h4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; x = 4'h1; y = 4'h1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        s_at_done = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                s_at_done = s;
            end
        end
        checkOutput("ignore_pulses", 32'(pulses), 32'd1);
        checkOutput("ignore_s", 32'(s_at_done), 32'h7);
        checkOutput("ignore_ovf", 32'(overflow), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ignore_s_hold", 32'(s), 32'h7);

        // reset mid-operation aborts without a done pulse
        @(negedge clk);
        start = 1'b1; op = 1'b1; x = 4'h2; y = 4'h6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_s", 32'(s), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_ovf", 32'(overflow), 32'd0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checkOutput("abort_no_done", 32'(pulses), 32'd0);
        prev_s = '0;
        applyStimulus(1'b1, 4'h2, 4'h6, lat);
        checkOutput("after_abort_latency", 32'(lat), 32'(N));
        checkOutput("after_abort_s", 32'(s), 32'hC);
        checkOutput("after_abort_cout", 32'(cout), 32'd0);
        checkOutput("after_abort_ovf", 32'(overflow), 32'd0);
        prev_s = 4'hC;
        @(posedge clk); #1;

        // start held high: back-to-back operations every n+2 cycles
        @(negedge clk);
        start = 1'b1; op = 1'b0; x = 4'h1; y = 4'h1;
        pulses = 0;
        for (int cyc = 1; cyc <= 40 && pulses < 3; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                t[pulses] = cyc;
                pulses++;
                checkOutput($sformatf("held_s%0d", pulses), 32'(s), 32'h2);
            end
        end
        start = 1'b0;
        checkOutput("held_pulses", 32'(pulses), 32'd3);
        if (pulses == 3) begin
            checkOutput("held_gap1", 32'(t[1] - t[0]), 32'd6);
            checkOutput("held_gap2", 32'(t[2] - t[1]), 32'd6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
- Multi-cycle sequencer for a two's-complement add/sub datapath.
- Time-shares one full-adder cell across all n bit positions, LSB first, one bit per clock.
- Sits between a control unit issuing start/op and any consumer of s/cout/overflow.
- Area-reduced alternative to the parallel subtractor; same flag semantics: cout is the raw carry out, overflow is the signed overflow.

Parameters:
- n, 4, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request; accepted only when busy=0.
- op  input  1  0 = add (x+y), 1 = subtract (x-y).
- x  input  n  operand A, two's complement; sampled on the accepting edge only.
- y  input  n  operand B, two's complement; sampled on the accepting edge only.
- busy  output  1  high from the accepting edge until the DONE cycle ends.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- s  output  n  result; holds last value until the next accepted start.
- cout  output  1  carry out of bit n-1.
- overflow  output  1  signed overflow of the completed operation.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, s=0, cout=0, overflow=0; bit counter, shift registers and carry cleared.
- Reset has priority over everything. Reset mid-operation aborts; no done pulse is produced.
- States:
  - IDLE: busy=0. If start=1, go to CALC and:
    - load a_sh=x;
    - load b_sh = op ? ~y : y;
    - set carry=op;
    - clear cnt=0 and res_sh=0;
    - latch x[n-1] and b[n-1] sign bits.
  - CALC: busy=1. Each edge:
    - sum = a_sh[0]^b_sh[0]^carry;
    - carry = majority(a_sh[0], b_sh[0], carry);
    - shift a_sh and b_sh right by 1;
    - shift sum into MSB of res_sh;
    - cnt++.
    - When the edge processes bit cnt=n-1, go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle. On entry:
    - s = res_sh;
    - cout = final carry;
    - overflow = (xs & bs & ~s[n-1]) | (~xs & ~bs & s[n-1]).
    - Next edge returns to IDLE unconditionally.
- Latency: with start accepted at edge T, done is high in the cycle following edge T+n. Throughput is one operation per n+2 cycles.
- start while busy=1: ignored, not queued; inputs x, y, op are don't-care.
- start held high continuously: a new operation is accepted at the first edge in IDLE after each DONE.
- s, cout and overflow change only on DONE entry or reset. They are stable while the next operation runs.
- Arithmetic is modulo 2^n. Subtraction is x + ~y + 1. For y = most-negative, x-y wraps and overflow is flagged per the formula above.
- done is a registered output with no combinational path from start.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined: on DONE entry, if overflow=1, s saturates instead of wrapping:
  - s = 2^(n-1)-1 when xs=0;
  - s = -2^(n-1) when xs=1.
  - overflow and cout still report the unsaturated result.
- Undefined: s is always the wrapped modulo-2^n result.

Test Plan:
- n=4, op=1, x=5, y=3 -> done after edge T+4; s=4'b0010, cout=1, overflow=0; busy high exactly 5 cycles.
- n=4, op=0, x=7, y=1 -> s=4'b1000, cout=0, overflow=1. With SERIAL_ADDSUB_SAT_EN: s=4'b0111, overflow=1.
- n=4, op=1, x=-8 (4'b1000), y=1 -> s=4'b0111, cout=1, overflow=1. With SERIAL_ADDSUB_SAT_EN: s=4'b1000.
- n=4, op=0, x=3, y=4, then pulse start with x=1, y=1 two cycles later -> second start ignored; s=7, overflow=0, exactly one done pulse; s holds 7 until a new start.
- n=4, op=1, x=2, y=6; drop rst_n for one edge at T+2 -> no done pulse; busy=0, s=0, cout=0, overflow=0 after that edge. A following start with x=2, y=6 -> s=4'b1100, cout=0, overflow=0.
- start tied high for 3 ops (n=4, x=1, y=1, op=0) -> done pulses spaced exactly 6 cycles apart; s=2 each time.
